// File: rtl/branch_pkg.sv
// Shared types for the branch tracker: FSM states, queued branch entries
// and default sizing.
package branch_pkg;

   localparam int DEF_DEPTH = 4;
   localparam int DEF_PC_W  = 32;
   localparam int DEF_CNT_W = 16;

   typedef enum logic [0:0] {
      IDLE      = 1'b0,
      WAIT_PRED = 1'b1
   } state_t;

   // The entry layout follows the package PC width.
   typedef struct packed {
      logic [DEF_PC_W-1:0] pc;
      logic                pred;
   } entry_t;

   function automatic logic is_wrong(input entry_t e, input logic taken);
      return e.pred != taken;
   endfunction

endpackage

// File: rtl/branch_tracker_if.sv
// Fetch / predictor / execute signals of the branch tracker, with debug
// visibility of the FSM state and queue occupancy.
interface branch_tracker_if
   import branch_pkg::*;
#(
   parameter int PC_W  = DEF_PC_W,
   parameter int CNT_W = DEF_CNT_W,
   parameter int DEPTH = DEF_DEPTH
);
   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // Ready never depends on the valid of the same channel; fetch_ready does
   // depend on resolve_valid because resolution wins the predictor port.
   logic                     fetch_valid;
   logic [PC_W-1:0]          fetch_pc;
   logic                     fetch_ready;
   logic                     pred_request;
   logic                     pred_result;
   logic                     pred_taken;
   logic                     pred_in;
   logic                     predict_valid;
   logic                     predict_taken;
   logic                     resolve_valid;
   logic                     resolve_taken;
   logic                     resolve_ready;
   logic                     mispredict;
   logic [PC_W-1:0]          mispredict_pc;
   logic [CNT_W-1:0]         resolved_cnt;
   logic [CNT_W-1:0]         mispredict_cnt;
   state_t                   dbg_state;
   logic [$clog2(DEPTH):0]   dbg_count;

   modport slave (
      input  fetch_valid, fetch_pc, pred_in, resolve_valid, resolve_taken,
      output fetch_ready, pred_request, pred_result, pred_taken,
             predict_valid, predict_taken, resolve_ready, mispredict,
             mispredict_pc, resolved_cnt, mispredict_cnt, dbg_state, dbg_count
   );

   modport master (
      output fetch_valid, fetch_pc, pred_in, resolve_valid, resolve_taken,
      input  fetch_ready, pred_request, pred_result, pred_taken,
             predict_valid, predict_taken, resolve_ready, mispredict,
             mispredict_pc, resolved_cnt, mispredict_cnt, dbg_state, dbg_count
   );

endinterface

// File: rtl/branch_fifo.sv
// In-order queue of predicted branches with push, pop and a synchronous
// flush that wins over both.
module branch_fifo
   import branch_pkg::*;
#(
   parameter int  DEPTH = DEF_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_push,
   input  logic        i_pop,
   input  logic        i_flush,
   input  entry_t      i_data,
   output entry_t      o_head,
   output logic        o_full,
   output logic        o_empty,
   output logic [AW:0] o_count
);

   entry_t        r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full && !i_flush;
   assign w_do_pop  = i_pop && !o_empty && !i_flush;

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
      end
   end

endmodule

// File: rtl/branch_tracker.sv
// Fetch-side branch tracker: requests predictions, queues them in order and
// trains the predictor on resolution, redirecting fetch on a wrong guess.
module branch_tracker
   import branch_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int PC_W  = DEF_PC_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input logic              clk,
   input logic              rst,
   branch_tracker_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [PC_W-1:0]   r_fetch_pc;
   logic              r_mispredict;
   logic [PC_W-1:0]   r_mispredict_pc;
   logic [CNT_W-1:0]  r_resolved_cnt;
   logic [CNT_W-1:0]  r_mispredict_cnt;

   entry_t            w_head;
   entry_t            w_new_entry;
   logic              w_full;
   logic              w_empty;
   logic [AW:0]       w_count;
   logic              w_resolve_acc;
   logic              w_wrong;
   logic              w_fetch_ready;
   logic              w_fetch_acc;
   logic              w_push;
   logic              w_predict_valid;

   assign w_resolve_acc = bus.resolve_valid && !w_empty;
   assign w_wrong       = w_resolve_acc && is_wrong(w_head, bus.resolve_taken);
   // Resolution owns the predictor port, so a pending resolve blocks fetch.
   assign w_fetch_ready = (r_state == IDLE) && !w_full && !r_mispredict &&
                          !(bus.resolve_valid && !w_empty);
   assign w_fetch_acc   = bus.fetch_valid && w_fetch_ready;
   // A redirect on the same edge drops the in-flight capture.
   assign w_push        = (r_state == WAIT_PRED) && !w_wrong;
   assign w_new_entry   = '{pc: r_fetch_pc, pred: bus.pred_in};

   branch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_resolve_acc),
      .i_flush (w_wrong),
      .i_data  (w_new_entry),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_comb begin
      w_state_nxt     = r_state;
      w_predict_valid = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_fetch_acc) w_state_nxt = WAIT_PRED;
         end
         WAIT_PRED: begin
            w_predict_valid = 1'b1;
            w_state_nxt     = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state          <= IDLE;
         r_fetch_pc       <= '0;
         r_mispredict     <= 1'b0;
         r_mispredict_pc  <= '0;
         r_resolved_cnt   <= '0;
         r_mispredict_cnt <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_mispredict <= w_wrong;
         if (w_fetch_acc)   r_fetch_pc      <= bus.fetch_pc;
         if (w_wrong)       r_mispredict_pc <= w_head.pc;
         if (w_resolve_acc) r_resolved_cnt  <= r_resolved_cnt + CNT_W'(1);
         if (w_wrong)       r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
      end
   end

   assign bus.fetch_ready    = w_fetch_ready;
   assign bus.pred_request   = w_fetch_acc;
   assign bus.pred_result    = w_resolve_acc;
   assign bus.pred_taken     = bus.resolve_taken;
   assign bus.predict_valid  = w_predict_valid;
   assign bus.predict_taken  = w_predict_valid && bus.pred_in;
   assign bus.resolve_ready  = !w_empty;
   assign bus.mispredict     = r_mispredict;
   assign bus.mispredict_pc  = r_mispredict_pc;
   assign bus.resolved_cnt   = r_resolved_cnt;
   assign bus.mispredict_cnt = r_mispredict_cnt;
   assign bus.dbg_state      = r_state;
   assign bus.dbg_count      = w_count;

endmodule

// File: tb/tb_branch_tracker.sv
// Self-checking bench for branch_tracker: scoreboard of queued predictions,
// resolved against a model of the in-order queue and statistics counters.
module tb_branch_tracker;
   import branch_pkg::*;

   localparam int DEPTH = 4;
   localparam int PC_W  = 32;
   localparam int CNT_W = 16;

   logic clk;
   logic rst;

   branch_tracker_if #(.PC_W(PC_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) bif ();

   branch_tracker #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, need finish");
      $fatal(1, "watchdog");
   end

   logic [PC_W:0] exp_q[$];
   int            n_cmp = 0;
   int            n_err = 0;
   int            exp_resolved = 0;
   int            exp_mispred  = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic do_fetch(input logic [PC_W-1:0] pc, input logic pred);
      int waited = 0;
      @(posedge clk); #1;
      bif.fetch_valid = 1'b1;
      bif.fetch_pc    = pc;
      bif.pred_in     = pred;
      @(negedge clk);
      while (!bif.fetch_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!bif.fetch_ready) begin
         check_val("fetch_ready_timeout", 64'(bif.fetch_ready), 64'd1);
         bif.fetch_valid = 1'b0;
         return;
      end
      check_val("pred_request", 64'(bif.pred_request), 64'd1);
      check_val("no_result_on_fetch", 64'(bif.pred_result), 64'd0);
      exp_q.push_back({pc, pred});
      @(posedge clk); #1;
      bif.fetch_valid = 1'b0;
      @(negedge clk);
      check_val("predict_valid", 64'(bif.predict_valid), 64'd1);
      check_val("predict_taken", 64'(bif.predict_taken), 64'(pred));
      @(posedge clk); #1;
      @(negedge clk);
      check_val("count_after_fetch", 64'(bif.dbg_count), 64'(exp_q.size()));
   endtask

   task automatic do_resolve(input logic taken);
      logic [PC_W:0] e;
      logic          wrong;
      @(posedge clk); #1;
      bif.resolve_valid = 1'b1;
      bif.resolve_taken = taken;
      @(negedge clk);
      check_val("resolve_ready", 64'(bif.resolve_ready), 64'd1);
      check_val("pred_result", 64'(bif.pred_result), 64'd1);
      check_val("pred_taken", 64'(bif.pred_taken), 64'(taken));
      check_val("no_request_on_resolve", 64'(bif.pred_request), 64'd0);
      e = exp_q.pop_front();
      wrong = (e[0] != taken);
      exp_resolved++;
      @(posedge clk); #1;
      bif.resolve_valid = 1'b0;
      @(negedge clk);
      check_val("mispredict", 64'(bif.mispredict), 64'(wrong));
      if (wrong) begin
         exp_mispred++;
         exp_q.delete();
         check_val("mispredict_pc", 64'(bif.mispredict_pc), 64'(e[PC_W:1]));
         check_val("fetch_ready_redirect", 64'(bif.fetch_ready), 64'd0);
      end
      check_val("count_after_resolve", 64'(bif.dbg_count), 64'(exp_q.size()));
      check_val("resolved_cnt", 64'(bif.resolved_cnt), 64'(exp_resolved));
      check_val("mispredict_cnt", 64'(bif.mispredict_cnt), 64'(exp_mispred));
   endtask

   initial begin
      logic [PC_W:0] e;
      rst               = 1'b1;
      bif.fetch_valid   = 1'b0;
      bif.fetch_pc      = '0;
      bif.pred_in       = 1'b0;
      bif.resolve_valid = 1'b0;
      bif.resolve_taken = 1'b0;
      #12;
      check_val("rst_state", 64'(bif.dbg_state), 64'(IDLE));
      check_val("rst_count", 64'(bif.dbg_count), 64'd0);
      check_val("rst_pred_request", 64'(bif.pred_request), 64'd0);
      check_val("rst_pred_result", 64'(bif.pred_result), 64'd0);
      check_val("rst_predict_valid", 64'(bif.predict_valid), 64'd0);
      check_val("rst_resolve_ready", 64'(bif.resolve_ready), 64'd0);
      check_val("rst_mispredict", 64'(bif.mispredict), 64'd0);
      check_val("rst_mispredict_pc", 64'(bif.mispredict_pc), 64'd0);
      check_val("rst_resolved_cnt", 64'(bif.resolved_cnt), 64'd0);
      check_val("rst_mispredict_cnt", 64'(bif.mispredict_cnt), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Single branch, correctly predicted not-taken.
      do_fetch(32'h100, 1'b0);
      do_resolve(1'b0);

      // Fill the queue, then hold a fifth fetch until a resolve frees a slot.
      for (int i = 0; i < DEPTH; i++)
         do_fetch(32'h200 + 32'(4 * i), 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
      bif.fetch_valid = 1'b1;
      bif.fetch_pc    = 32'h210;
      bif.pred_in     = 1'b1;
      @(negedge clk);
      check_val("full_fetch_ready", 64'(bif.fetch_ready), 64'd0);
      check_val("full_pred_request", 64'(bif.pred_request), 64'd0);
      @(posedge clk); #1;
      bif.resolve_valid = 1'b1;
      bif.resolve_taken = exp_q[0][0];
      @(negedge clk);
      check_val("full_resolve_result", 64'(bif.pred_result), 64'd1);
      check_val("full_resolve_blocks_fetch", 64'(bif.fetch_ready), 64'd0);
      void'(exp_q.pop_front());
      exp_resolved++;
      @(posedge clk); #1;
      bif.resolve_valid = 1'b0;
      @(negedge clk);
      check_val("held_fetch_ready", 64'(bif.fetch_ready), 64'd1);
      check_val("held_pred_request", 64'(bif.pred_request), 64'd1);
      exp_q.push_back({32'h210, 1'b1});
      @(posedge clk); #1;
      bif.fetch_valid = 1'b0;
      @(negedge clk);
      check_val("held_predict_taken", 64'(bif.predict_taken), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check_val("held_count", 64'(bif.dbg_count), 64'd4);
      check_val("held_resolved_cnt", 64'(bif.resolved_cnt), 64'(exp_resolved));

      // Drain to two entries, then resolve and fetch in the same cycle.
      do_resolve(exp_q[0][0]);
      do_resolve(exp_q[0][0]);
      @(posedge clk); #1;
      bif.resolve_valid = 1'b1;
      bif.resolve_taken = exp_q[0][0];
      bif.fetch_valid   = 1'b1;
      bif.fetch_pc      = 32'h300;
      bif.pred_in       = 1'b0;
      @(negedge clk);
      check_val("both_pred_result", 64'(bif.pred_result), 64'd1);
      check_val("both_pred_request", 64'(bif.pred_request), 64'd0);
      void'(exp_q.pop_front());
      exp_resolved++;
      @(posedge clk); #1;
      bif.resolve_valid = 1'b0;
      @(negedge clk);
      check_val("both_fetch_next", 64'(bif.pred_request), 64'd1);
      exp_q.push_back({32'h300, 1'b0});
      @(posedge clk); #1;
      bif.fetch_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check_val("both_count", 64'(bif.dbg_count), 64'd2);

      // Drain with random outcomes; the model decides where redirects land.
      while (exp_q.size() > 0) do_resolve(1'($urandom_range(0, 1)));

      // Directed mispredict on the oldest of three.
      do_fetch(32'h10, 1'b1);
      do_fetch(32'h14, 1'b0);
      do_fetch(32'h18, 1'b0);
      do_resolve(1'b0);

      // Random mix of fetches and resolutions.
      for (int i = 0; i < 30; i++) begin
         if (exp_q.size() < DEPTH && (exp_q.size() == 0 || $urandom_range(0, 1) == 1))
            do_fetch(32'h1000 + 32'($urandom_range(0, 255) * 4), 1'($urandom_range(0, 1)));
         else
            do_resolve(1'($urandom_range(0, 1)));
      end
      while (exp_q.size() > 0) do_resolve(1'($urandom_range(0, 1)));

      // Asynchronous reset while a fourth capture is in flight.
      do_fetch(32'h40, 1'b1);
      do_fetch(32'h44, 1'b0);
      do_fetch(32'h48, 1'b1);
      @(posedge clk); #1;
      bif.fetch_valid = 1'b1;
      bif.fetch_pc    = 32'h4C;
      bif.pred_in     = 1'b1;
      @(negedge clk);
      check_val("pre_rst_request", 64'(bif.pred_request), 64'd1);
      @(posedge clk); #1;
      bif.fetch_valid = 1'b0;
      #2;
      check_val("pre_rst_wait_pred", 64'(bif.dbg_state), 64'(WAIT_PRED));
      rst = 1'b1;
      #1;
      check_val("async_rst_state", 64'(bif.dbg_state), 64'(IDLE));
      check_val("async_rst_count", 64'(bif.dbg_count), 64'd0);
      check_val("async_rst_predict_valid", 64'(bif.predict_valid), 64'd0);
      check_val("async_rst_resolve_ready", 64'(bif.resolve_ready), 64'd0);
      check_val("async_rst_resolved_cnt", 64'(bif.resolved_cnt), 64'd0);
      check_val("async_rst_mispredict_cnt", 64'(bif.mispredict_cnt), 64'd0);
      exp_q.delete();
      exp_resolved = 0;
      exp_mispred  = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_val("post_rst_count", 64'(bif.dbg_count), 64'd0);
      check_val("post_rst_mispredict", 64'(bif.mispredict), 64'd0);

      // One more transaction confirms the queue restarts cleanly.
      do_fetch(32'h500, 1'b1);
      e = exp_q[0];
      check_val("post_rst_head_pc", 64'(e[PC_W:1]), 64'h500);
      do_resolve(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
